// File: rtl/fft_adder_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
// Holds the saturation-mode encodings and a constant-foldable ceil(log2).
package fft_adder_pkg;

   localparam int unsigned SAT_WRAP_FULL = 0;
   localparam int unsigned SAT_CLAMP     = 1;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = unsigned'(i) + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered level of the adder tree: adds adjacent operand pairs and registers them.
// The final level may clamp its result to OUT_W bits and raise a sticky overflow flag.
module adder_stage #(
   parameter int unsigned IN_W  = 10,
   parameter int unsigned N_IN  = 4,
   parameter int unsigned OUT_W = IN_W + 1,
   parameter bit          CLAMP = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [N_IN*IN_W-1:0]      in_data,
   input  logic                      in_valid,
   input  logic                      in_ovf,
   output logic [(N_IN/2)*OUT_W-1:0] out_data,
   output logic                      out_valid,
   output logic                      out_ovf
);

   localparam int unsigned N_OUT = N_IN / 2;
   localparam int unsigned PAIR_W = IN_W + 1;
   // Largest value representable in OUT_W bits, expressed at full pair-sum width.
   localparam logic [PAIR_W-1:0] PAIR_MAX = {PAIR_W{1'b1}} >> (PAIR_W - OUT_W);

   logic [N_OUT*OUT_W-1:0] data_d, data_q;
   logic [PAIR_W-1:0]      pair_sum;
   logic                   ovf_d, ovf_q;
   logic                   valid_q;

   always_comb begin
      data_d   = '0;
      ovf_d    = in_ovf;
      pair_sum = '0;
      for (int k = 0; k < N_OUT; k++) begin
         pair_sum = PAIR_W'(in_data[2*k*IN_W +: IN_W]) + PAIR_W'(in_data[(2*k+1)*IN_W +: IN_W]);
         if (CLAMP && (pair_sum > PAIR_MAX)) begin
            pair_sum = PAIR_MAX;
            ovf_d    = 1'b1;
         end
         data_d[k*OUT_W +: OUT_W] = OUT_W'(pair_sum);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else if (en) begin
         valid_q <= in_valid;
         // Bubbles advance the valid bit only; data is left alone to save toggling.
         if (in_valid) begin
            data_q <= data_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_ovf   = ovf_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined unsigned adder tree with valid/ready handshake and optional saturation.
// One registered tree level per log2 step; a stalled output freezes the whole pipeline.
module pipelined_adder_tree
   import fft_adder_pkg::*;
#(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned N_OPS    = 4,
   parameter int unsigned SAT_MODE = SAT_WRAP_FULL,
   localparam int unsigned L       = clog2(N_OPS),
   localparam int unsigned SUM_W   = (SAT_MODE == SAT_WRAP_FULL) ? WIDTH + L : WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_OPS*WIDTH-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [SUM_W-1:0]       out_sum,
   output logic                   out_ovf,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int unsigned N_LEAF = 1 << L;

   logic [N_LEAF*WIDTH-1:0] leaves;
   logic                    stall;

   // Missing leaves of a non-power-of-two tree are zero.
   assign leaves   = (N_LEAF*WIDTH)'(in_data);
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   for (genvar j = 1; j <= L; j++) begin : g_lvl
      localparam int unsigned IN_W  = WIDTH + j - 1;
      localparam int unsigned N_IN  = N_LEAF >> (j - 1);
      localparam int unsigned OUT_W = (j == L) ? SUM_W : IN_W + 1;

      logic [N_IN*IN_W-1:0]      d_in;
      logic                      v_in;
      logic                      o_in;
      logic [(N_IN/2)*OUT_W-1:0] d_out;
      logic                      v_out;
      logic                      o_out;

      if (j == 1) begin : g_first
         assign d_in = leaves;
         assign v_in = in_valid;
         assign o_in = 1'b0;
      end else begin : g_next
         assign d_in = g_lvl[j-1].d_out;
         assign v_in = g_lvl[j-1].v_out;
         assign o_in = g_lvl[j-1].o_out;
      end

      adder_stage #(
         .IN_W  (IN_W),
         .N_IN  (N_IN),
         .OUT_W (OUT_W),
         .CLAMP ((j == L) && (SAT_MODE == SAT_CLAMP))
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (!stall),
         .in_data   (d_in),
         .in_valid  (v_in),
         .in_ovf    (o_in),
         .out_data  (d_out),
         .out_valid (v_out),
         .out_ovf   (o_out)
      );
   end

   assign out_sum   = g_lvl[L].d_out;
   assign out_valid = g_lvl[L].v_out;
   assign out_ovf   = g_lvl[L].o_out;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench: three tree configurations against a queue-based arithmetic model.
module tb_pipelined_adder_tree;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Shared stimulus for the two WIDTH=10, N_OPS=4 instances (full and saturating).
   logic [39:0] a_data;
   logic        a_valid, a_rdy;
   logic        d0_in_ready, d0_out_ovf, d0_out_valid;
   logic [11:0] d0_out_sum;
   logic        d1_in_ready, d1_out_ovf, d1_out_valid;
   logic [9:0]  d1_out_sum;
   // WIDTH=8, N_OPS=5 instance.
   logic [39:0] b_data;
   logic        b_valid, b_rdy;
   logic        d2_in_ready, d2_out_ovf, d2_out_valid;
   logic [10:0] d2_out_sum;

   int n_checks = 0;
   int n_errs   = 0;
   int n_out0 = 0, n_out1 = 0, n_out2 = 0;

   longint unsigned q0s[$], q1s[$], q2s[$];
   bit              q1o[$];
   longint unsigned t1;

   pipelined_adder_tree #(.WIDTH(10), .N_OPS(4), .SAT_MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(d0_in_ready),
      .out_sum(d0_out_sum), .out_ovf(d0_out_ovf), .out_valid(d0_out_valid), .out_ready(a_rdy)
   );
   pipelined_adder_tree #(.WIDTH(10), .N_OPS(4), .SAT_MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(d1_in_ready),
      .out_sum(d1_out_sum), .out_ovf(d1_out_ovf), .out_valid(d1_out_valid), .out_ready(a_rdy)
   );
   pipelined_adder_tree #(.WIDTH(8), .N_OPS(5), .SAT_MODE(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(d2_in_ready),
      .out_sum(d2_out_sum), .out_ovf(d2_out_ovf), .out_valid(d2_out_valid), .out_ready(b_rdy)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic longint unsigned op_sum(input logic [39:0] d, input int n, input int w);
      longint unsigned t;
      logic [39:0]     mask;
      t    = 0;
      mask = (40'd1 << w) - 40'd1;
      for (int k = 0; k < n; k++) t += 64'((d >> (k * w)) & mask);
      return t;
   endfunction

   // Scoreboards: record accepted sets, compare every consumed output in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         q0s.delete();
      end else begin
         check_eq("rdy0", d0_in_ready, !(d0_out_valid && !a_rdy));
         if (d0_out_valid && a_rdy) begin
            n_out0++;
            if (q0s.size() == 0) check_eq("spur0", d0_out_valid, 0);
            else begin
               check_eq("sum0", d0_out_sum, q0s.pop_front());
               check_eq("ovf0", d0_out_ovf, 0);
            end
         end
         if (a_valid && d0_in_ready) q0s.push_back(op_sum(a_data, 4, 10));
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q1s.delete();
         q1o.delete();
      end else begin
         check_eq("rdy1", d1_in_ready, !(d1_out_valid && !a_rdy));
         if (d1_out_valid && a_rdy) begin
            n_out1++;
            if (q1s.size() == 0) check_eq("spur1", d1_out_valid, 0);
            else begin
               check_eq("sum1", d1_out_sum, q1s.pop_front());
               check_eq("ovf1", d1_out_ovf, q1o.pop_front());
            end
         end
         if (a_valid && d1_in_ready) begin
            t1 = op_sum(a_data, 4, 10);
            q1s.push_back((t1 > 1023) ? 1023 : t1);
            q1o.push_back(t1 > 1023);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q2s.delete();
      end else begin
         check_eq("rdy2", d2_in_ready, !(d2_out_valid && !b_rdy));
         if (d2_out_valid && b_rdy) begin
            n_out2++;
            if (q2s.size() == 0) check_eq("spur2", d2_out_valid, 0);
            else begin
               check_eq("sum2", d2_out_sum, q2s.pop_front());
               check_eq("ovf2", d2_out_ovf, 0);
            end
         end
         if (b_valid && d2_in_ready) q2s.push_back(op_sum(b_data, 5, 8));
      end
   end

   // Single set on the shared pair; measures latency and checks fixed expected values.
   task automatic run_a(input logic [39:0] data, input longint unsigned e0,
                        input longint unsigned e1, input logic e1_ovf);
      int lat;
      @(posedge clk); #1;
      a_data  = data;
      a_valid = 1'b1;
      a_rdy   = 1'b1;
      lat     = 0;
      do begin
         @(posedge clk); #1;
         a_valid = 1'b0;
         lat++;
         @(negedge clk);
      end while (!d0_out_valid && lat < 20);
      check_eq("lat_a", lat, 2);
      check_eq("dir_sum0", d0_out_sum, e0);
      check_eq("dir_ovf0", d0_out_ovf, 0);
      check_eq("dir_sum1", d1_out_sum, e1);
      check_eq("dir_ovf1", d1_out_ovf, e1_ovf);
   endtask

   task automatic run_b(input logic [39:0] data, input longint unsigned e2);
      int lat;
      @(posedge clk); #1;
      b_data  = data;
      b_valid = 1'b1;
      b_rdy   = 1'b1;
      lat     = 0;
      do begin
         @(posedge clk); #1;
         b_valid = 1'b0;
         lat++;
         @(negedge clk);
      end while (!d2_out_valid && lat < 20);
      check_eq("lat_b", lat, 3);
      check_eq("dir_sum2", d2_out_sum, e2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n, guard, start;
      rst_n   = 1'b0;
      a_data  = '0;
      a_valid = 1'b0;
      a_rdy   = 1'b0;
      b_data  = '0;
      b_valid = 1'b0;
      b_rdy   = 1'b0;

      // Reset state, with out_ready low to show no stall is possible in reset.
      @(negedge clk);
      check_eq("rst_valid0", d0_out_valid, 0);
      check_eq("rst_sum0", d0_out_sum, 0);
      check_eq("rst_ovf0", d0_out_ovf, 0);
      check_eq("rst_ready0", d0_in_ready, 1);
      check_eq("rst_valid1", d1_out_valid, 0);
      check_eq("rst_ovf1", d1_out_ovf, 0);
      check_eq("rst_valid2", d2_out_valid, 0);
      check_eq("rst_ready2", d2_in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      a_rdy = 1'b1;
      b_rdy = 1'b1;
      repeat (2) @(posedge clk);

      // Directed sets with hand-computed results.
      run_a({10'd4, 10'd3, 10'd2, 10'd1}, 10, 10, 1'b0);
      run_a({4{10'd1023}}, 4092, 1023, 1'b1);
      run_a({10'd0, 10'd0, 10'd523, 10'd500}, 1023, 1023, 1'b0);
      run_a({10'd0, 10'd0, 10'd0, 10'd1}, 1, 1, 1'b0);
      run_b({5{8'd255}}, 1275);
      run_b({8'd1, 8'd0, 8'd0, 8'd0, 8'd0}, 1);

      // Back-to-back sets 1..20 with out_ready toggling pseudo-randomly.
      @(posedge clk); #1;
      start = n_out0;
      n     = 1;
      guard = 0;
      while (n <= 20 && guard < 2000) begin
         @(posedge clk); #1;
         a_valid = 1'b1;
         a_data  = {4{10'(n)}};
         a_rdy   = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (d0_in_ready) n++;
         guard++;
      end
      check_eq("b2b_sent", n, 21);
      @(posedge clk); #1;
      a_valid = 1'b0;
      a_rdy   = 1'b1;
      repeat (8) @(posedge clk);
      check_eq("b2b_count", n_out0 - start, 20);

      // Stall: output held for 8 cycles while a new set waits at the input.
      @(posedge clk); #1;
      a_data  = {4{10'd1023}};
      a_valid = 1'b1;
      a_rdy   = 1'b0;
      @(posedge clk); #1;
      a_valid = 1'b0;
      guard   = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!d0_out_valid && guard < 20);
      check_eq("stall_arrive", d0_out_valid, 1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         a_valid = 1'b1;
         a_data  = {4{10'd1}};
         @(negedge clk);
         check_eq("stall_sum0", d0_out_sum, 4092);
         check_eq("stall_sum1", d1_out_sum, 1023);
         check_eq("stall_ovf1", d1_out_ovf, 1);
         check_eq("stall_ready", d0_in_ready, 0);
      end
      @(posedge clk); #1;
      a_rdy = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      repeat (6) @(posedge clk);

      // Reset pulse with two sets in flight: nothing may emerge afterwards.
      @(posedge clk); #1;
      a_valid = 1'b1;
      a_data  = {4{10'd7}};
      @(posedge clk); #1;
      a_data  = {4{10'd9}};
      @(posedge clk); #1;
      a_valid = 1'b0;
      a_rdy   = 1'b0;
      rst_n   = 1'b0;
      #1;
      check_eq("rstp_valid0", d0_out_valid, 0);
      check_eq("rstp_valid1", d1_out_valid, 0);
      check_eq("rstp_sum0", d0_out_sum, 0);
      check_eq("rstp_ready0", d0_in_ready, 1);
      start = n_out0 + n_out1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      a_rdy = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_eq("rstp_quiet", n_out0 + n_out1 - start, 0);

      // Randomized traffic on all instances.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         a_valid = 1'($urandom_range(0, 1));
         a_data  = {8'($urandom), 32'($urandom)};
         if ($urandom_range(0, 1) == 1) a_data = a_data & {4{10'h0ff}};
         a_rdy   = ($urandom_range(0, 3) != 0);
         b_valid = 1'($urandom_range(0, 1));
         b_data  = {8'($urandom), 32'($urandom)};
         b_rdy   = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_rdy   = 1'b1;
      b_rdy   = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check_eq("drain0", q0s.size(), 0);
      check_eq("drain1", q1s.size(), 0);
      check_eq("drain2", q2s.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
